aes_req_arbiter: RTL and testbench
==================================

AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, max cycles waited for core_done before error completion (legal range 2..1023).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rstn  input  1  asynchronous active-low reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_plain / req0_key  input  128 each  requester 0 operands.
REQ-007 Port: req1_valid / req1_ready / req1_plain / req1_key  same as requester 0.
REQ-008 Port: rsp_valid  output  1  response available.
REQ-009 Port: rsp_ready  input  1  consumer accepts response.
REQ-010 Port: rsp_id  output  1  requester owning the response.
REQ-011 Port: rsp_data  output  128  cipher text.
REQ-012 Port: rsp_err  output  1  response ended by timeout.
REQ-013 Port: core_start  output  1  one-cycle start pulse to the shared cipher core.
REQ-014 Port: core_plain_text / core_key  output  128 each  operands driven to the core.
REQ-015 Port: core_cipher_text  input  128  core result.
REQ-016 Port: core_done  input  1  core result valid.
REQ-017 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, BUSY and RESP, encoded in a 2-bit register.
- IDLE: if any reqN_valid is high, grant one requester, assert its reqN_ready for exactly that cycle, latch its operands and ID, then go to ISSUE.
- ISSUE: assert core_start for one cycle, clear the timeout counter, then go to BUSY.
- BUSY: on the first cycle core_done is high, latch core_cipher_text into rsp_data, set rsp_err=0, and go to RESP.
- RESP: hold rsp_valid=1 with rsp_id, rsp_data and rsp_err stable until rsp_valid and rsp_ready are both high, then go to IDLE.
REQ-019 Arbitration SHALL be round-robin: when both requests are valid, grant the requester not granted last; when one is valid, grant it; last_grant SHALL update only on a grant.
REQ-020 reqN_ready SHALL never be asserted outside IDLE, and never for both requesters in the same cycle.
REQ-021 core_plain_text and core_key SHALL come from the latched registers and stay stable from ISSUE until RESP is exited.
REQ-022 core_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-023 Minimum latency SHALL be:
- accept at cycle N;
- core_start at N+1;
- rsp_valid at D+1, where D is the first BUSY cycle with core_done=1.
REQ-024 The timeout counter SHALL increment every BUSY cycle; when it reaches TIMEOUT without core_done, go to RESP with rsp_err=1 and rsp_data=0.
REQ-025 If core_done and the timeout occur in the same cycle, done SHALL win (rsp_err=0).
REQ-026 A requester that drops reqN_valid before being granted SHALL lose its place without side effects.
REQ-027 After RESP exits to IDLE, a new grant SHALL be possible on the very next cycle, so back-to-back operations are separated by exactly one IDLE cycle.

Reset
REQ-028 While rstn=0, the block SHALL be in IDLE with:
- last_grant=1, so requester 0 wins the first contention;
- all outputs 0, including core_start, rsp_valid, rsp_err, rsp_id, rsp_data, core operands and busy;
- the counter at 0.
REQ-029 Reset asserted mid-operation SHALL abort immediately with no response issued; after release the block SHALL accept new requests normally.

Verification
REQ-030 The bench SHALL cover: FIPS-197 single op: req0 with key 000102030405060708090a0b0c0d0e0f, plain 00112233445566778899aabbccddeeff, core model done after 10 cycles -> one core_start pulse, rsp_valid with rsp_id=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
REQ-031 The bench SHALL cover: both requests valid from reset, three ops each -> grant order 0,1,0,1,0,1 and rsp_id matching that order.
REQ-032 The bench SHALL cover: core model never asserts done, TIMEOUT=64 -> rsp_valid exactly 64 cycles after the first BUSY cycle, with rsp_err=1 and rsp_data=0.
REQ-033 The bench SHALL cover: rsp_ready held low for 20 cycles -> rsp outputs stable, no reqN_ready and no core_start during the stall.
REQ-034 The bench SHALL cover: rstn pulsed low during BUSY -> all outputs 0 asynchronously, no response; the next req1 is served normally.
REQ-035 The bench SHALL cover: a stale core_done pulse injected in IDLE and in ISSUE -> ignored, and the response carries the later, correct result.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for a shared AES cipher core.
// Grants one operation at a time, starts the core, waits for done (or a
// timeout), then holds the response until the consumer takes it.
module aes_req_arbiter #(
    parameter int unsigned TIMEOUT = 64  // legal range 2..1023
) (
    input  logic         clk,
    input  logic         rstn,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_plain,
    input  logic [127:0] req0_key,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_plain,
    input  logic [127:0] req1_key,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_data,
    output logic         rsp_err,

    output logic         core_start,
    output logic [127:0] core_plain_text,
    output logic [127:0] core_key,
    input  logic [127:0] core_cipher_text,
    input  logic         core_done,

    output logic         busy
);

    localparam int unsigned DW = 128;
    localparam int unsigned CW = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            id_q, id_d;
    logic [DW-1:0]   plain_q, plain_d;
    logic [DW-1:0]   key_q, key_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            gnt0_c, gnt1_c;

    // State and datapath registers; reset leaves requester 0 favoured on first contention
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            plain_q      <= '0;
            key_q        <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            plain_q      <= plain_d;
            key_q        <= key_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Next-state, round-robin grant, operand capture and timeout handling
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        plain_d      = plain_q;
        key_d        = key_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        gnt0_c       = 1'b0;
        gnt1_c       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req0_valid && req1_valid) begin
                    gnt0_c = last_grant_q;
                    gnt1_c = !last_grant_q;
                end else begin
                    gnt0_c = req0_valid;
                    gnt1_c = req1_valid;
                end
                if (gnt0_c || gnt1_c) begin
                    id_d         = gnt1_c;
                    last_grant_d = gnt1_c;
                    plain_d      = gnt1_c ? req1_plain : req0_plain;
                    key_d        = gnt1_c ? req1_key   : req0_key;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // done has priority over a timeout landing in the same cycle
                if (core_done) begin
                    rsp_data_d = core_cipher_text;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is a same-cycle handshake; held low while reset is asserted
    assign req0_ready      = gnt0_c && rstn;
    assign req1_ready      = gnt1_c && rstn;

    // Remaining outputs are decodes of registered state
    assign core_start      = (state_q == S_ISSUE);
    assign rsp_valid       = (state_q == S_RESP);
    assign busy            = (state_q != S_IDLE);
    assign rsp_id          = id_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_err         = rsp_err_q;
    assign core_plain_text = plain_q;
    assign core_key        = key_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized directed bench for aes_req_arbiter with a behavioural core model.
module tb_aes_req_arbiter;

    localparam int TO = 64;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rstn;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [127:0] req0_plain, req0_key, req1_plain, req1_key;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [127:0] rsp_data;
    logic         core_start, core_done;
    logic [127:0] core_plain_text, core_key, core_cipher_text;
    logic         busy;

    int  n_chk  = 0;
    int  n_fail = 0;
    int  core_lat = 0;
    bit  last_g = 1'b1;
    logic inj_done = 1'b0;
    logic model_done = 1'b0;
    int  mcnt = 0;
    logic [127:0] mres = '0;

    aes_req_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_plain(req0_plain), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_plain(req1_plain), .req1_key(req1_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_start(core_start), .core_plain_text(core_plain_text),
        .core_key(core_key), .core_cipher_text(core_cipher_text),
        .core_done(core_done), .busy(busy)
    );

    always #5 clk = ~clk;

    assign core_done = model_done | inj_done;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in cipher: real AES for the FIPS-197 vector, a keyed mix otherwise
    function automatic logic [127:0] cipher_of(input logic [127:0] p, input logic [127:0] k);
        if (p == FIPS_P && k == FIPS_K) return FIPS_C;
        return p ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    // Core model: done pulses core_lat cycles after the start cycle (0 = never)
    always @(negedge clk) begin
        model_done = 1'b0;
        if (!rstn) begin
            mcnt = 0;
        end else begin
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) model_done = 1'b1;
            end
            if (core_start) begin
                mcnt = core_lat;
                mres = cipher_of(core_plain_text, core_key);
            end
        end
        core_cipher_text = model_done ? mres : rand128();
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation from grant to handshake; called at a negedge while IDLE
    task automatic run_txn(input bit v0, input bit v1, input int lat, input int stall,
                           input bit inj_issue, input bit drop_other);
        bit g, ee;
        logic [127:0] ep, ek, ed;
        int off, eoff, bad;
        core_lat   = lat;
        req0_valid = v0;
        req1_valid = v1;
        g      = (v0 && v1) ? !last_g : v1;
        last_g = g;
        ep   = g ? req1_plain : req0_plain;
        ek   = g ? req1_key   : req0_key;
        ee   = (lat == 0) || (lat > TO);
        ed   = ee ? 128'h0 : cipher_of(ep, ek);
        eoff = ee ? TO + 1 : lat + 1;
        #1;
        chk("req0_ready_grant", req0_ready, !g);
        chk("req1_ready_grant", req1_ready, g);
        @(negedge clk);
        if (g) begin
            req1_valid = 1'b0; req1_plain = rand128(); req1_key = rand128();
        end else begin
            req0_valid = 1'b0; req0_plain = rand128(); req0_key = rand128();
        end
        inj_done = inj_issue;
        chk("issue_core_start", core_start, 1'b1);
        chk("issue_busy", busy, 1'b1);
        chk("issue_readies", {req0_ready, req1_ready}, 2'b00);
        chk("core_plain", core_plain_text, ep);
        chk("core_key", core_key, ek);
        bad = 0;
        off = 0;
        while (off < 300) begin
            @(negedge clk);
            inj_done = 1'b0;
            off++;
            if (rsp_valid) break;
            if (core_start || req0_ready || req1_ready || !busy ||
                core_plain_text !== ep || core_key !== ek) bad++;
        end
        chk("rsp_latency", off, eoff);
        chk("rsp_id", rsp_id, g);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", rsp_err, ee);
        chk("busy_phase_clean", bad, 0);
        if (stall > 0) begin
            rsp_ready = 1'b0;
            bad = 0;
            for (int i = 0; i < stall; i++) begin
                if (i == stall / 2) inj_done = 1'b1;
                if (drop_other && i == stall / 2) begin
                    if (g) req0_valid = 1'b0; else req1_valid = 1'b0;
                end
                @(negedge clk);
                inj_done = 1'b0;
                if (!rsp_valid || rsp_id !== g || rsp_data !== ed || rsp_err !== ee ||
                    core_start || req0_ready || req1_ready ||
                    core_plain_text !== ep || core_key !== ek) bad++;
            end
            chk("stall_stable", bad, 0);
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_rsp_idle", busy, 1'b0);
    endtask

    initial begin
        int rem0, rem1, bad;
        rstn       = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_plain = rand128(); req0_key = rand128();
        req1_plain = rand128(); req1_key = rand128();
        repeat (3) @(negedge clk);

        // Reset values with both requests already pending
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_data", rsp_data, 128'h0);
        chk("rst_core_plain", core_plain_text, 128'h0);
        chk("rst_core_key", core_key, 128'h0);
        chk("rst_busy", busy, 1'b0);
        rstn = 1'b1;

        // Round robin: both pending from reset, three ops each
        rem0 = 3; rem1 = 3;
        for (int i = 0; i < 6; i++) begin
            run_txn(rem0 > 0, rem1 > 0, int'($urandom_range(1, 15)), 0, 1'b0, 1'b0);
            if (last_g) rem1--; else rem0--;
        end

        // Stale done in IDLE, then FIPS-197 vector with stale done in ISSUE
        req0_plain = FIPS_P;
        req0_key   = FIPS_K;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("idle_done_ignored", {busy, rsp_valid}, 2'b00);
        run_txn(1'b1, 1'b0, 10, 0, 1'b1, 1'b0);

        // Stale done in ISSUE with random operands
        run_txn(1'b0, 1'b1, int'($urandom_range(2, 30)), 0, 1'b1, 1'b0);

        // Timeout, done on the timeout cycle, and done one cycle too late
        run_txn(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, TO, 0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, TO + 1, 0, 1'b0, 1'b0);

        // Consumer stall with the other requester waiting, then dropping out
        run_txn(1'b1, 1'b1, 8, 20, 1'b0, 1'b1);
        run_txn(1'b1, 1'b0, int'($urandom_range(1, 20)), 0, 1'b0, 1'b0);

        // Reset pulse in BUSY aborts the op
        core_lat   = 20;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("abort_grant", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_in_busy", busy, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_core_start", core_start, 1'b0);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_rsp_err", rsp_err, 1'b0);
        chk("abort_rsp_id", rsp_id, 1'b0);
        chk("abort_rsp_data", rsp_data, 128'h0);
        chk("abort_core_plain", core_plain_text, 128'h0);
        chk("abort_core_key", core_key, 128'h0);
        last_g = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid || busy || core_start) bad++;
        end
        chk("abort_no_response", bad, 0);
        run_txn(1'b0, 1'b1, int'($urandom_range(1, 20)), 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b1, int'($urandom_range(1, 20)), 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
